// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture
//
// Watches a multiplexed, active-low 4-digit seven-segment display bus and
// reconstructs the digits being shown.
//
// Operation:
//   - The raw bus is synchronised by two flops.
//   - A digit is captured once the synchronised tuple {anode, seg, dp} has
//     held still for STABLE_CYCLES consecutive samples.
//   - Once all four digits have been captured, the whole frame is published.
//
// Ports:
//   clkIn        rising-edge clock for every flop
//   rstIn        asynchronous, active-low reset
//   segIn[6:0]   segment lines, active-low, bit0 = A .. bit6 = G
//   decimalIn    decimal-point line, active-low
//   anodeIn[3:0] digit selects, active-low one-hot, bit0 = rightmost digit
//   clearErrIn   synchronous clear of errorOut (an error event wins)
//   digitsOut    four 5-bit codes, [4:0] = digit 0
//                  0-9      = numeral
//                  5'h1F    = blank
//                  5'h1E    = invalid pattern
//   decimalsOut  captured decimal-point lines, raw active-low, one per digit
//   validOut     one-cycle pulse when a new frame appears on the outputs
//   errorOut     sticky error flag
// -----------------------------------------------------------------------------
module seg_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clkIn,
   input  logic        rstIn,
   input  logic [6:0]  segIn,
   input  logic        decimalIn,
   input  logic [3:0]  anodeIn,
   input  logic        clearErrIn,
   output logic [19:0] digitsOut,
   output logic [3:0]  decimalsOut,
   output logic        validOut,
   output logic        errorOut
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Tuple layout: {anode[3:0], seg[6:0], dp}
   logic [11:0]      sync1_q, sync1_d;
   logic [11:0]      sync2_q, sync2_d;
   logic [11:0]      t_prev_q, t_prev_d;
   state_t           state_q, state_d;
   logic [7:0]       stab_cnt_q, stab_cnt_d;
   logic [3:0]       seen_q, seen_d;
   logic [3:0][4:0]  shadow_code_q, shadow_code_d;
   logic [3:0]       shadow_dp_q, shadow_dp_d;
   logic [19:0]      digits_q, digits_d;
   logic [3:0]       decimals_q, decimals_d;
   logic             valid_q, valid_d;
   logic             error_q, error_d;

   logic [11:0]      t_cur;
   logic [3:0]       anode_t;
   logic [6:0]       seg_t;
   logic             dp_t;
   logic             onehot_low;
   logic             multi_low;
   logic             changed;
   logic [1:0]       dig_idx;
   logic [4:0]       code_t;
   logic [7:0]       stab_inc;
   logic             capture;
   logic             publish;
   logic             err_event;

   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] code;
      case (seg)
         7'h40:   code = 5'd0;
         7'h79:   code = 5'd1;
         7'h24:   code = 5'd2;
         7'h30:   code = 5'd3;
         7'h19:   code = 5'd4;
         7'h12:   code = 5'd5;
         7'h02:   code = 5'd6;
         7'h78:   code = 5'd7;
         7'h00:   code = 5'd8;
         7'h10:   code = 5'd9;
         7'h7F:   code = 5'h1F;
         default: code = 5'h1E;
      endcase
      return code;
   endfunction

   assign t_cur   = sync2_q;
   assign anode_t = t_cur[11:8];
   assign seg_t   = t_cur[7:1];
   assign dp_t    = t_cur[0];

   always_comb begin
      onehot_low = (anode_t == 4'hE) || (anode_t == 4'hD) ||
                   (anode_t == 4'hB) || (anode_t == 4'h7);
      multi_low  = ($countones(~anode_t) > 1);
      changed    = (t_cur != t_prev_q);
      code_t     = decode_seg(seg_t);
      stab_inc   = stab_cnt_q + 8'd1;
      case (anode_t)
         4'hD:    dig_idx = 2'd1;
         4'hB:    dig_idx = 2'd2;
         4'h7:    dig_idx = 2'd3;
         default: dig_idx = 2'd0;
      endcase
   end

   always_comb begin
      sync1_d       = {anodeIn, segIn, decimalIn};
      sync2_d       = sync1_q;
      t_prev_d      = t_cur;
      state_d       = state_q;
      stab_cnt_d    = stab_cnt_q;
      seen_d        = seen_q;
      shadow_code_d = shadow_code_q;
      shadow_dp_d   = shadow_dp_q;
      digits_d      = digits_q;
      decimals_d    = decimals_q;
      valid_d       = 1'b0;
      capture       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (onehot_low) begin
               stab_cnt_d = 8'd1;
               state_d    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (changed) begin
               stab_cnt_d = 8'd1;
               state_d    = onehot_low ? ST_SETTLE : ST_IDLE;
            end else begin
               stab_cnt_d = stab_inc;
               if (stab_inc == 8'(STABLE_CYCLES)) begin
                  capture = 1'b1;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (changed) begin
               if (onehot_low) begin
                  stab_cnt_d = 8'd1;
                  state_d    = ST_SETTLE;
               end else begin
                  stab_cnt_d = 8'd0;
                  state_d    = ST_IDLE;
               end
            end
         end
         default: begin
            stab_cnt_d = 8'd0;
            state_d    = ST_IDLE;
         end
      endcase

      // A full seen mask was completed on the previous edge: publish now.
      // A capture cannot land on this same edge (it needs a stable run of at
      // least two samples after a change), but it is handled anyway.
      publish = (seen_q == 4'hF);
      if (publish) begin
         digits_d   = shadow_code_q;
         decimals_d = shadow_dp_q;
         valid_d    = 1'b1;
         seen_d     = 4'h0;
      end

      if (capture) begin
         shadow_code_d[dig_idx] = code_t;
         shadow_dp_d[dig_idx]   = dp_t;
         seen_d[dig_idx]        = 1'b1;
      end

      err_event = multi_low || (capture && (code_t == 5'h1E));
      if (err_event)
         error_d = 1'b1;
      else if (clearErrIn)
         error_d = 1'b0;
      else
         error_d = error_q;
   end

   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         sync1_q       <= '1;
         sync2_q       <= '1;
         t_prev_q      <= '1;
         state_q       <= ST_IDLE;
         stab_cnt_q    <= 8'd0;
         seen_q        <= 4'h0;
         shadow_code_q <= {4{5'h1F}};
         shadow_dp_q   <= 4'hF;
         digits_q      <= 20'hFFFFF;
         decimals_q    <= 4'hF;
         valid_q       <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         t_prev_q      <= t_prev_d;
         state_q       <= state_d;
         stab_cnt_q    <= stab_cnt_d;
         seen_q        <= seen_d;
         shadow_code_q <= shadow_code_d;
         shadow_dp_q   <= shadow_dp_d;
         digits_q      <= digits_d;
         decimals_q    <= decimals_d;
         valid_q       <= valid_d;
         error_q       <= error_d;
      end
   end

   assign digitsOut   = digits_q;
   assign decimalsOut = decimals_q;
   assign validOut    = valid_q;
   assign errorOut    = error_q;

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical synchronized samples required before a digit is captured.
REQ-002 SHALL provide port clkIn, input, 1: the single clock; every flop is clocked on its rising edge.
REQ-003 SHALL provide port rstIn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL provide port segIn, input, 7: segment lines, active-low, bit0=A through bit6=G.
REQ-005 SHALL provide port decimalIn, input, 1: decimal-point line, active-low.
REQ-006 SHALL provide port anodeIn, input, 4: digit selects, active-low, one-hot when valid; bit0 is the rightmost digit.
REQ-007 SHALL provide port clearErrIn, input, 1: synchronous clear of errorOut.
REQ-008 SHALL provide port digitsOut, output, 20: four 5-bit digit codes; [4:0] is digit 0.
REQ-009 SHALL provide port decimalsOut, output, 4: captured decimal lines, raw active-low, one per digit.
REQ-010 SHALL provide port validOut, output, 1: one-cycle pulse when a complete frame is published.
REQ-011 SHALL provide port errorOut, output, 1: sticky error flag.

Function
REQ-012 SHALL pass segIn, decimalIn and anodeIn through a 2-flop synchronizer; all other logic uses only the synchronized tuple T={anode,seg,dp}.
REQ-013 SHALL decode segment patterns as 0:7'h40, 1:7'h79, 2:7'h24, 3:7'h30, 4:7'h19, 5:7'h12, 6:7'h02, 7:7'h78, 8:7'h00, 9:7'h10 to codes 0-9, decode 7'h7F (blank) to 5'h1F, and decode any other pattern to 5'h1E (invalid).
REQ-014 SHALL implement FSM states IDLE, SETTLE and HOLD.
REQ-015 IDLE: when the anode field of T is one-hot low, SHALL load stabCnt=1 and go to SETTLE; otherwise SHALL remain in IDLE.
REQ-016 SETTLE: if T differs from the previous cycle's T, SHALL reset stabCnt to 1, stay in SETTLE (or go to IDLE if the anode is not one-hot), and perform no capture.
REQ-017 SETTLE: if T is unchanged, SHALL increment stabCnt; when stabCnt reaches STABLE_CYCLES, SHALL capture the decoded code and dp into the shadow slot of the selected digit, set that digit's seen bit, and go to HOLD.
REQ-018 HOLD: SHALL make no further capture while T is unchanged; on any change of T, SHALL go to SETTLE (anode one-hot, stabCnt=1) or to IDLE.
REQ-019 A recapture of a digit whose seen bit is already set SHALL overwrite its shadow slot.
REQ-020 The cycle after the capture that makes seen=4'hF, SHALL copy the shadow slots to digitsOut/decimalsOut, pulse validOut high for exactly 1 cycle, and clear seen to 0.
REQ-021 digitsOut/decimalsOut SHALL change only on validOut cycles.
REQ-022 SHALL set errorOut when an anode field with more than one low bit is sampled, or when a 5'h1E code is captured; an invalid capture SHALL still set its seen bit.
REQ-023 clearErrIn SHALL clear errorOut the next cycle; if an error event occurs in the same cycle, set SHALL win.
REQ-024 All-high anode (blanking) SHALL be a legal non-error condition that returns the FSM to IDLE.

Reset
REQ-025 When rstIn is low, SHALL immediately force: state=IDLE, stabCnt=0, seen=0, synchronizers=all ones, shadows=5'h1F, digitsOut=20'hFFFFF, decimalsOut=4'hF, validOut=0, errorOut=0.
REQ-026 Reset asserted mid-frame SHALL discard partial captures; after release, no validOut SHALL occur until four new captures complete.

Verification
REQ-027 Scan of "1234" (anode 4'hE..4'h7, segs 79/24/30/19, dp high), 8 cycles dwell each, STABLE_CYCLES=4 -> single validOut, digitsOut={5'd4,5'd3,5'd2,5'd1}=20'h20C41, errorOut=0.
REQ-028 Digit 0 glitches segIn 7'h79->7'h24 after 2 cycles, then holds 7'h24 for 6 cycles -> slot 0 captures code 2 and no capture of code 1 occurs.
REQ-029 Dwell of exactly STABLE_CYCLES-1 cycles on digit 3 -> no capture and no validOut for that scan; a following full scan -> validOut.
REQ-030 anodeIn=4'hC for 5 cycles -> errorOut=1; clearErrIn pulsed -> errorOut=0 next cycle; clearErrIn coincident with another 4'hC sample -> errorOut stays 1.
REQ-031 segIn=7'h55 held on digit 2 through a full scan -> digit 2 code 5'h1E published, errorOut=1.
REQ-032 rstIn driven low after 3 digits are captured -> outputs at reset values immediately; after release, a single digit scan produces no validOut.
